// File: rtl/clock_pkg.sv
// Shared digital-clock types and constants: 7-segment byte type, digit codes
// ({dp,g,f,e,d,c,b,a}, active-high) and the 24-hour upper bound.
package clock_pkg;

  typedef logic [7:0] seg7_t;

  localparam seg7_t SEG_0     = 8'h3F;
  localparam seg7_t SEG_1     = 8'h06;
  localparam seg7_t SEG_2     = 8'h5B;
  localparam seg7_t SEG_3     = 8'h4F;
  localparam seg7_t SEG_4     = 8'h66;
  localparam seg7_t SEG_5     = 8'h6D;
  localparam seg7_t SEG_6     = 8'h7D;
  localparam seg7_t SEG_7     = 8'h07;
  localparam seg7_t SEG_8     = 8'h7F;
  localparam seg7_t SEG_9     = 8'h6F;
  localparam seg7_t SEG_BLANK = 8'h00;

  localparam int HOUR_MAX_24 = 23;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes blank the
// digit. Shared by the hour stage and the display scanner.
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hour_digit.sv
// Hour stage: BCD hour counter advanced by tick_h/set_inc, registered segment
// bytes decoded from next state, day-rollover pulse. Macro HOUR_DIGIT_12H_EN selects 12-hour AM/PM mode.
module hour_digit
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_h,
  input  logic       set_inc,
  output seg7_t      seg_data_h_1,
  output seg7_t      seg_data_h_10,
  output logic [7:0] hour_bcd,
  output logic       day_out
);

`ifdef HOUR_DIGIT_12H_EN
  localparam logic [1:0] RST_TENS = 2'd1;
  localparam logic [3:0] RST_ONES = 4'd2;
  localparam seg7_t      RST_SEG10 = SEG_1;
  localparam seg7_t      RST_SEG1  = SEG_2;
`else
  localparam logic [1:0] RST_TENS = 2'd0;
  localparam logic [3:0] RST_ONES = 4'd0;
  localparam seg7_t      RST_SEG10 = SEG_0;
  localparam seg7_t      RST_SEG1  = SEG_0;
  localparam logic [1:0] TENS_MAX = 2'(HOUR_MAX_24 / 10);
  localparam logic [3:0] ONES_MAX = 4'(HOUR_MAX_24 % 10);
`endif

  logic [1:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       day_q, day_d;
  seg7_t      seg1_q, seg1_d;
  seg7_t      seg10_q, seg10_d;
  seg7_t      dec_ones, dec_tens;
  logic       adv;
`ifdef HOUR_DIGIT_12H_EN
  logic       pm_q, pm_d;
`endif

  assign adv = tick_h | set_inc;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    day_d  = 1'b0;
`ifdef HOUR_DIGIT_12H_EN
    pm_d   = pm_q;
    if (adv) begin
      if (tens_q == 2'd1 && ones_q == 4'd2) begin
        tens_d = 2'd0;
        ones_d = 4'd1;
      end else if (tens_q == 2'd1 && ones_q == 4'd1) begin
        // 11 -> 12 flips AM/PM; only the PM-to-AM flip by the minute stage is a new day
        ones_d = 4'd2;
        pm_d   = ~pm_q;
        day_d  = tick_h & pm_q;
      end else if (ones_q == 4'd9) begin
        tens_d = 2'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
`else
    if (adv) begin
      if (tens_q == TENS_MAX && ones_q == ONES_MAX) begin
        tens_d = 2'd0;
        ones_d = 4'd0;
        day_d  = tick_h;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 2'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
`endif
  end

  bcd_to_seg7 u_dec_ones (.bcd(ones_d),          .seg(dec_ones));
  bcd_to_seg7 u_dec_tens (.bcd({2'b00, tens_d}), .seg(dec_tens));

  always_comb begin
`ifdef HOUR_DIGIT_12H_EN
    seg10_d = (tens_d == 2'd0) ? SEG_BLANK : dec_tens;
    seg1_d  = {pm_d, dec_ones[6:0]};
`else
    seg10_d = dec_tens;
    seg1_d  = dec_ones;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q  <= RST_TENS;
      ones_q  <= RST_ONES;
      day_q   <= 1'b0;
      seg1_q  <= RST_SEG1;
      seg10_q <= RST_SEG10;
`ifdef HOUR_DIGIT_12H_EN
      pm_q    <= 1'b0;
`endif
    end else begin
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      day_q   <= day_d;
      seg1_q  <= seg1_d;
      seg10_q <= seg10_d;
`ifdef HOUR_DIGIT_12H_EN
      pm_q    <= pm_d;
`endif
    end
  end

  assign hour_bcd      = {2'b00, tens_q, ones_q};
  assign seg_data_h_1  = seg1_q;
  assign seg_data_h_10 = seg10_q;
  assign day_out       = day_q;

endmodule

// File: tb/tb_hour_digit.sv
// Self-checking bench for hour_digit: directed vector table, corner sequences and
// random stimulus against an hours-since-midnight reference model.
module tb_hour_digit;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tick_h  = 1'b0;
  logic       set_inc = 1'b0;
  logic [7:0] seg_data_h_1;
  logic [7:0] seg_data_h_10;
  logic [7:0] hour_bcd;
  logic       day_out;

  int passed = 0;
  int total  = 0;
  int model_h = 0;
  bit model_day = 1'b0;
  int day_cnt;

  int seg_tbl[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  typedef struct {
    bit t;
    bit s;
    bit r;
    int exp_h;
    bit exp_day;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  hour_digit dut (
    .clk          (clk),
    .rst          (rst),
    .tick_h       (tick_h),
    .set_inc      (set_inc),
    .seg_data_h_1 (seg_data_h_1),
    .seg_data_h_10(seg_data_h_10),
    .hour_bcd     (hour_bcd),
    .day_out      (day_out)
  );

  // Reference: hours since midnight 0..23; display format derived afterwards.
  task automatic applyStimulus(input bit t, input bit s, input bit r);
    @(negedge clk);
    tick_h  = t;
    set_inc = s;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) begin
      model_h   = 0;
      model_day = 1'b0;
    end else if (t || s) begin
      model_day = t && (model_h == 23);
      model_h   = (model_h + 1) % 24;
    end else begin
      model_day = 1'b0;
    end
  endtask

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input int h, input bit dexp);
    int disp, tens, ones;
    logic [7:0] e10, e1;
`ifdef HOUR_DIGIT_12H_EN
    disp = (h % 12 == 0) ? 12 : h % 12;
`else
    disp = h;
`endif
    tens = disp / 10;
    ones = disp % 10;
    e10  = 8'(seg_tbl[tens]);
    e1   = 8'(seg_tbl[ones]);
`ifdef HOUR_DIGIT_12H_EN
    if (tens == 0) e10 = 8'h00;
    if (h >= 12) e1 = e1 | 8'h80;
`endif
    compare({name, " hour_bcd"}, hour_bcd, {4'(tens), 4'(ones)});
    compare({name, " seg_h_10"}, seg_data_h_10, e10);
    compare({name, " seg_h_1"}, seg_data_h_1, e1);
    compare({name, " day_out"}, {7'b0, day_out}, {7'b0, dexp});
  endtask

  task automatic stepModel(input string name, input bit t, input bit s, input bit r);
    applyStimulus(t, s, r);
    checkOutput(name, model_h, model_day);
    if (day_out) day_cnt++;
  endtask

  initial begin
    $display("[TB] starting hour_digit bench");

    // {tick, set, rst, expected hour since midnight, expected day_out}
    vecs.push_back('{0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 2, 0});
    vecs.push_back('{1, 1, 0, 3, 0});
    vecs.push_back('{0, 0, 0, 3, 0});
    vecs.push_back('{1, 0, 0, 4, 0});
    vecs.push_back('{0, 1, 0, 5, 0});
    vecs.push_back('{1, 0, 0, 6, 0});
    vecs.push_back('{1, 0, 0, 7, 0});
    vecs.push_back('{1, 1, 0, 8, 0});
    vecs.push_back('{0, 1, 0, 9, 0});
    vecs.push_back('{1, 0, 0, 10, 0});
    vecs.push_back('{0, 0, 0, 10, 0});
    vecs.push_back('{1, 0, 1, 0, 0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].t, vecs[i].s, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_h, vecs[i].exp_day);
    end

    // 24 minute-stage ticks spaced three cycles apart: one full day from midnight
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    day_cnt = 0;
    for (int p = 0; p < 24; p++) begin
      stepModel($sformatf("day_tick%0d", p), 1, 0, 0);
      stepModel($sformatf("day_idle%0da", p), 0, 0, 0);
      stepModel($sformatf("day_idle%0db", p), 0, 0, 0);
    end
    compare("day_pulse_count", 8'(day_cnt), 8'd1);
    checkOutput("after_full_day", 0, 1'b0);

    // Walk to the last hour with set_inc, then wrap by set_inc alone
    for (int p = 0; p < 23; p++) stepModel($sformatf("set_walk%0d", p), 0, 1, 0);
    checkOutput("at_last_hour", 23, 1'b0);
    day_cnt = 0;
    stepModel("set_wrap", 0, 1, 0);
    stepModel("set_wrap_idle", 0, 0, 0);
    compare("set_wrap_day_count", 8'(day_cnt), 8'd0);

    // Both advance sources at the last hour still signal a new day
    for (int p = 0; p < 23; p++) stepModel($sformatf("both_walk%0d", p), 1, 0, 0);
    stepModel("both_wrap", 1, 1, 0);
    checkOutput("both_wrap_exp", 0, 1'b1);
    stepModel("both_wrap_idle", 0, 0, 0);

    // Reset mid-count wins over a coincident tick
    for (int p = 0; p < 15; p++) stepModel($sformatf("rst_walk%0d", p), 0, 1, 0);
    stepModel("rst_with_tick", 1, 0, 1);
    checkOutput("rst_with_tick_exp", 0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      stepModel($sformatf("rand%0d", n),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
